// File: rtl/pipeline_drain_buf_pkg.sv
// Shared definitions for the pipeline drain buffer: default parameters,
// width helpers and the per-cycle event bundle.
package pipeline_drain_buf_pkg;

  localparam int DEF_LATENCY = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;

  typedef struct packed {
    logic issue;
    logic arrive;
    logic pop;
  } drain_ev_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipeline_valid_track.sv
// Resettable 1-bit shadow of the external pipeline: marks which cycles carry
// a result that was actually issued.
module pipeline_valid_track #(
  parameter int LATENCY = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fire,
  output logic o_arr
);

  logic [LATENCY-1:0] stage;

  if (LATENCY == 1) begin : g_one
    always_ff @(posedge i_clk) begin
      if (i_rst) stage <= '0;
      else       stage <= i_fire;
    end
  end else begin : g_multi
    always_ff @(posedge i_clk) begin
      if (i_rst) stage <= '0;
      else       stage <= {stage[LATENCY-2:0], i_fire};
    end
  end

  assign o_arr = stage[LATENCY-1];

endmodule

// File: rtl/pipeline_drain_buf.sv
// Credit-protected catch FIFO behind a reset-less fixed-latency datapath;
// credits guarantee every issued result has a slot when it emerges.
module pipeline_drain_buf
  import pipeline_drain_buf_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_issue_valid,
  output logic                         o_issue_ready,
  input  logic [WIDTH-1:0]             i_pipe_data,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  input  logic                         i_ready,
  output logic [clog2(DEPTH+1)-1:0]    o_count,
  output logic                         o_overflow
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  if (LATENCY < 1 || DEPTH < 2 || !is_pow2(DEPTH)) begin : g_param_err
    $error("pipeline_drain_buf: illegal LATENCY/DEPTH");
  end

  logic [CW-1:0]    cred;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             arr;
  logic             full;
  logic             ovf;
  drain_ev_t        ev;

  assign full = (count == CW'(DEPTH));

  always_comb begin
    ev        = '0;
    ev.issue  = i_issue_valid && o_issue_ready;
    ev.pop    = o_valid && i_ready;
    ev.arrive = arr && !full;
  end

  pipeline_valid_track #(
    .LATENCY (LATENCY)
  ) u_track (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_fire (ev.issue),
    .o_arr  (arr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cred <= CW'(DEPTH);
    end else begin
      case ({ev.issue, ev.pop})
        2'b10:   cred <= cred - 1'b1;
        2'b01:   cred <= cred + 1'b1;
        default: cred <= cred;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (ev.arrive) wr_ptr <= wr_ptr + 1'b1;
      if (ev.pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({ev.arrive, ev.pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Only reachable if the credit accounting is broken; the write is dropped.
      if (arr && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ev.arrive) mem[wr_ptr] <= i_pipe_data;
  end

  assign o_issue_ready = (cred != '0);
  assign o_valid       = (count != '0);
  assign o_data        = mem[rd_ptr];
  assign o_count       = count;
  assign o_overflow    = ovf;

endmodule

// File: tb/tb_pipeline_drain_buf.sv
// Scoreboard bench for pipeline_drain_buf with a 4-stage reset-less model of
// the external pipeline.
module tb_pipeline_drain_buf;

  localparam int LATENCY = 4;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_issue_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] i_pipe_data;
  logic [WIDTH-1:0] issue_data = '0;
  logic             o_issue_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [3:0]       o_count;
  logic             o_overflow;

  logic [WIDTH-1:0] pipe [LATENCY];
  logic [WIDTH-1:0] sb [$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_pop   = 0;

  pipeline_drain_buf #(
    .LATENCY (LATENCY),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .o_issue_ready (o_issue_ready),
    .i_pipe_data   (i_pipe_data),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .i_ready       (i_ready),
    .o_count       (o_count),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // External datapath: plain delay line, no reset.
  always @(posedge i_clk) begin
    pipe[0] <= issue_data;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign i_pipe_data = pipe[LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Inputs only change just after posedge, so negedge sees what the next edge will see.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
    end else begin
      if (i_issue_valid && o_issue_ready) sb.push_back(issue_data);
      if (o_valid && i_ready) begin
        n_pop++;
        if (sb.size() == 0) chk("pop_unexpected", {24'd0, o_data}, 32'hFFFF_FFFF);
        else                chk("pop_data", {24'd0, o_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t reached, limit 50000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  nfire;
    bit  fire;

    repeat (3) step();
    @(negedge i_clk);
    chk("rst_ready", o_issue_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf",   o_overflow, 0);
    step();
    i_rst = 1'b0;
    repeat (5) step();

    // single item
    i_ready = 1'b1;
    issue_data = 8'h5A;
    i_issue_valid = 1'b1;
    step();
    i_issue_valid = 1'b0;
    issue_data = 8'h00;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      chk("single_valid", o_valid, (k == 4) ? 1 : 0);
      chk("single_count", o_count, (k == 4) ? 1 : 0);
      if (k == 4) chk("single_data", o_data, 8'h5A);
      step();
    end

    // streaming
    n_pop = 0;
    i_issue_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      issue_data = 8'(i);
      @(negedge i_clk);
      chk("stream_ready", o_issue_ready, 1);
      step();
    end
    i_issue_valid = 1'b0;
    repeat (8) step();
    @(negedge i_clk);
    chk("stream_pops", n_pop, 100);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_ovf", o_overflow, 0);
    step();

    // backpressure
    i_ready = 1'b0;
    issue_data = 8'h00;
    i_issue_valid = 1'b1;
    nfire = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge i_clk);
      fire = i_issue_valid && o_issue_ready;
      step();
      if (fire) begin
        nfire++;
        issue_data = issue_data + 8'd1;
      end
    end
    chk("bp_fires", nfire, 8);
    @(negedge i_clk);
    chk("bp_ready_low", o_issue_ready, 0);
    chk("bp_count", o_count, 8);
    step();
    i_issue_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_ready_before_pop", o_issue_ready, 0);
    step();
    @(negedge i_clk);
    chk("bp_ready_after_pop", o_issue_ready, 1);
    repeat (10) step();
    @(negedge i_clk);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_count_end", o_count, 0);
    step();

    // simultaneous arrival and pop at occupancy 3
    i_ready = 1'b0;
    i_issue_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      issue_data = 8'h40 + 8'(k);
      step();
    end
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      issue_data = 8'h47 + 8'(k);
      @(negedge i_clk);
      chk("sim_count", o_count, 3);
      chk("sim_ready", o_issue_ready, 1);
      step();
    end
    i_issue_valid = 1'b0;
    repeat (10) step();
    @(negedge i_clk);
    chk("sim_sb_empty", sb.size(), 0);
    step();

    // reset with 3 in flight and 2 buffered
    i_ready = 1'b0;
    i_issue_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      issue_data = 8'h60 + 8'(k);
      step();
    end
    i_issue_valid = 1'b0;
    step();
    @(negedge i_clk);
    chk("rstmid_pre_count", o_count, 2);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_count", o_count, 0);
    chk("rstmid_ready", o_issue_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk("rstmid_stale", o_valid, 0);
      step();
    end
    i_ready = 1'b1;
    issue_data = 8'hA1;
    i_issue_valid = 1'b1;
    step();
    i_issue_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      chk("rstmid_a1_valid", o_valid, (k == 4) ? 1 : 0);
      if (k == 4) chk("rstmid_a1_data", o_data, 8'hA1);
      step();
    end

    // forced arrival while full
    i_ready = 1'b0;
    i_issue_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      issue_data = 8'h80 + 8'(k);
      step();
    end
    i_issue_valid = 1'b0;
    @(negedge i_clk);
    chk("ovf_full", o_count, 8);
    chk("ovf_pre", o_overflow, 0);
    step();
    force dut.arr = 1'b1;
    step();
    release dut.arr;
    @(negedge i_clk);
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count", o_count, 8);
    repeat (3) step();
    @(negedge i_clk);
    chk("ovf_sticky", o_overflow, 1);
    step();
    i_ready = 1'b1;
    repeat (12) step();
    @(negedge i_clk);
    chk("ovf_sb_empty", sb.size(), 0);
    chk("ovf_drained", o_count, 0);
    chk("ovf_still_set", o_overflow, 1);
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("ovf_cleared", o_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
